// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared constants, entry type and pointer-width helper for the
//               fetch-to-decode instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    localparam int          FQ_XLEN         = 32;
    localparam int          FQ_DEPTH        = 4;
    // addi x0,x0,0 -- what decode sees while the queue has nothing to offer
    localparam logic [31:0] FQ_BUBBLE_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] instr;
        logic [FQ_XLEN-1:0] pc;
    } fq_entry_t;

    // Pointers carry one extra wrap bit above the index bits
    function automatic int fq_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int FQ_PTR_W = fq_ptr_width(FQ_DEPTH);

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-side and decode-side valid/ready handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc
    );
endinterface : fetch_queue_if
`default_nettype wire

// File: rtl/fetch_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fq_ptr
// Description : Wrap-bit read/write pointer pair with full/empty/count flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fq_ptr
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = fq_ptr_width(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             wr_inc,
    input  wire logic             rd_inc,
    input  wire logic             flush,
    output logic      [PTR_W-2:0] wr_idx,
    output logic      [PTR_W-2:0] rd_idx,
    output logic                  empty,
    output logic                  full,
    output logic      [PTR_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Flush empties the queue by pulling the write side back onto the read side
        if (flush) begin
            wr_ptr_d = rd_ptr_q;
        end else begin
            if (wr_inc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_inc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_idx = wr_ptr_q[PTR_W-2:0];
    assign rd_idx = rd_ptr_q[PTR_W-2:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]) &&
                    (wr_ptr_q[PTR_W-1]   != rd_ptr_q[PTR_W-1]);
    assign count  = wr_ptr_q - rd_ptr_q;

endmodule : fq_ptr
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : DEPTH-entry {instr, pc} FIFO between fetch and decode with
//               optional empty-queue bypass and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int              XLEN         = FQ_XLEN,
    parameter  int              DEPTH        = FQ_DEPTH,
    parameter  int              BYPASS       = 1,
    parameter  logic [XLEN-1:0] BUBBLE_INSTR = XLEN'(FQ_BUBBLE_INSTR),
    localparam int              PTR_W        = fq_ptr_width(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             flush,
    fetch_queue_if.slave          bus,
    output logic      [PTR_W-1:0] count
);

    logic [2*XLEN-1:0] mem_q [DEPTH];

    logic             alive_q, alive_d;
    logic [PTR_W-2:0] wr_idx;
    logic [PTR_W-2:0] rd_idx;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    logic             bypass_hit;
    logic             store_wr;
    logic             store_rd;
    logic [2*XLEN-1:0] head;

    // Holds in_ready low until the first edge after reset is released
    always_comb begin
        alive_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) alive_q <= 1'b0;
        else        alive_q <= alive_d;
    end

    assign bus.in_ready = alive_q & ~full & ~flush;
    assign enq          = bus.in_valid & bus.in_ready;

    generate
        if (BYPASS != 0) begin : g_bypass
            assign bypass_hit = empty & enq;
        end else begin : g_no_bypass
            assign bypass_hit = 1'b0;
        end
    endgenerate

    assign bus.out_valid = ~flush & (~empty | bypass_hit);
    assign deq           = bus.out_valid & bus.out_ready;

    // A bypassed entry consumed in the same cycle never touches storage
    assign store_wr = enq & ~(bypass_hit & bus.out_ready);
    assign store_rd = deq & ~empty;

    assign head          = empty ? {bus.in_instr, bus.in_pc} : mem_q[rd_idx];
    assign bus.out_instr = bus.out_valid ? head[2*XLEN-1:XLEN] : BUBBLE_INSTR;
    assign bus.out_pc    = bus.out_valid ? head[XLEN-1:0]      : '0;

    always_ff @(posedge clk) begin
        if (store_wr) mem_q[wr_idx] <= {bus.in_instr, bus.in_pc};
    end

    fq_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .wr_inc (store_wr),
        .rd_inc (store_rd),
        .flush  (flush),
        .wr_idx (wr_idx),
        .rd_idx (rd_idx),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed bench for fetch_queue, bypass and non-bypass builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [2:0] count_b;
    logic [2:0] count_n;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32)) bus_b ();
    fetch_queue_if #(.XLEN(32)) bus_n ();

    fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1), .BUBBLE_INSTR(32'h0000_0013)) u_byp (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_b.slave), .count(count_b));

    fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0), .BUBBLE_INSTR(32'h0000_0013)) u_nb (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_n.slave), .count(count_n));

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus_b.in_ready); end
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus_b.out_valid); end
        checks++; if (bus_b.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_out_instr: got %h want 00000013", bus_b.out_instr); end
        checks++; if (bus_b.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", bus_b.out_pc); end
        checks++; if (count_b !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_b); end
        checks++; if (bus_n.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_nb: got %b want 0", bus_n.in_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus_b.in_ready); end
        checks++; if (bus_n.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready_nb: got %b want 1", bus_n.in_ready); end
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", bus_b.out_valid); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus_b.in_valid = 1'b1; bus_b.in_pc = 32'h100; bus_b.in_instr = 32'h0050_0093; bus_b.out_ready = 1'b1;
        #1;
        checks++; if (bus_b.out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", bus_b.out_valid); end
        checks++; if (bus_b.out_pc !== 32'h100) begin errors++; $display("FAIL bypass_pc: got %h want 100", bus_b.out_pc); end
        checks++; if (bus_b.out_instr !== 32'h0050_0093) begin errors++; $display("FAIL bypass_instr: got %h want 00500093", bus_b.out_instr); end
        @(posedge clk);
        #1;
        checks++; if (count_b !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d want 0", count_b); end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        #1;
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL bypass_not_stored: got %b want 0", bus_b.out_valid); end
        bus_b.out_ready = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_b.in_valid = 1'b1; bus_b.in_pc = 32'(i * 4); bus_b.in_instr = 32'(32'h1000 + i); bus_b.out_ready = 1'b0;
        end
        @(negedge clk);
        bus_b.in_pc = 32'h10; bus_b.in_instr = 32'h1004;
        #1;
        checks++; if (count_b !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count_b); end
        checks++; if (bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", bus_b.in_ready); end
        @(negedge clk);
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (bus_b.out_valid !== 1'b1 || bus_b.out_pc !== 32'(i * 4))
                begin errors++; $display("FAIL fill_drain_%0d: got v=%b pc=%h want v=1 pc=%h", i, bus_b.out_valid, bus_b.out_pc, i * 4); end
        end
        @(negedge clk);
        #1;
        checks++; if (bus_b.out_valid !== 1'b0 || count_b !== 3'd0)
            begin errors++; $display("FAIL fill_refused: got v=%b count=%0d want v=0 count=0", bus_b.out_valid, count_b); end
        bus_b.out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bus_n.out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            bus_n.in_valid = (i < 10); bus_n.in_pc = 32'(i * 4); bus_n.in_instr = 32'(32'h2000 + i);
            #1;
            if (i == 0) begin
                checks++; if (bus_n.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_latency: got %b want 0", bus_n.out_valid); end
                checks++; if (count_n !== 3'd0) begin errors++; $display("FAIL wrap_count_0: got %0d want 0", count_n); end
            end else begin
                checks++; if (bus_n.out_valid !== 1'b1 || bus_n.out_pc !== 32'((i - 1) * 4))
                    begin errors++; $display("FAIL wrap_order_%0d: got v=%b pc=%h want v=1 pc=%h", i, bus_n.out_valid, bus_n.out_pc, (i - 1) * 4); end
                checks++; if (count_n !== 3'd1) begin errors++; $display("FAIL wrap_count_%0d: got %0d want 1", i, count_n); end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (bus_n.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained: got %b want 0", bus_n.out_valid); end
        bus_n.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_b.in_valid = 1'b1; bus_b.in_pc = 32'(32'h300 + i * 4); bus_b.in_instr = 32'h3000; bus_b.out_ready = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1; bus_b.in_valid = 1'b1; bus_b.in_pc = 32'h200; bus_b.out_ready = 1'b1;
        #1;
        checks++; if (count_b !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count_b); end
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus_b.out_valid); end
        checks++; if (bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus_b.in_ready); end
        checks++; if (bus_b.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL flush_bubble: got %h want 00000013", bus_b.out_instr); end
        @(negedge clk);
        flush = 1'b0; bus_b.in_valid = 1'b0;
        #1;
        checks++; if (count_b !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count_b); end
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b want 0", bus_b.out_valid); end
        bus_b.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_b.in_valid = 1'b1; bus_b.in_pc = 32'(32'h400 + i * 4); bus_b.in_instr = 32'h4000; bus_b.out_ready = 1'b0;
        end
        @(negedge clk);
        bus_b.in_pc = 32'h408; bus_b.out_ready = 1'b1;
        #1;
        checks++; if (bus_b.out_pc !== 32'h400) begin errors++; $display("FAIL b2b_head: got %h want 400", bus_b.out_pc); end
        checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", bus_b.in_ready); end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        #1;
        checks++; if (count_b !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", count_b); end
        checks++; if (bus_b.out_pc !== 32'h404) begin errors++; $display("FAIL b2b_second: got %h want 404", bus_b.out_pc); end
        @(negedge clk);
        #1;
        checks++; if (bus_b.out_pc !== 32'h408) begin errors++; $display("FAIL b2b_third: got %h want 408", bus_b.out_pc); end
        @(negedge clk);
        #1;
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", bus_b.out_valid); end
        bus_b.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_b.in_valid = 1'b1; bus_b.in_pc = 32'(32'h500 + i * 4); bus_b.in_instr = 32'h5000; bus_b.out_ready = 1'b0;
        end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        #1;
        checks++; if (count_b !== 3'd2) begin errors++; $display("FAIL areset_pre_count: got %0d want 2", count_b); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count_b !== 3'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", count_b); end
        checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b want 0", bus_b.out_valid); end
        checks++; if (bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready: got %b want 0", bus_b.in_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus_b.in_ready !== 1'b1 || count_b !== 3'd0)
            begin errors++; $display("FAIL areset_recover: got rdy=%b count=%0d want rdy=1 count=0", bus_b.in_ready, count_b); end
    endtask

    initial begin
        bus_b.in_valid = 1'b0; bus_b.in_instr = '0; bus_b.in_pc = '0; bus_b.out_ready = 1'b0;
        bus_n.in_valid = 1'b0; bus_n.in_instr = '0; bus_n.in_pc = '0; bus_n.out_ready = 1'b0;
        test_reset();
        test_bypass();
        test_fill();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
